// File: rtl/mem_stage.sv
// Load/store stage: forwards ALU results to writeback and runs loads/stores
// against a single-ported data RAM with a request/ready handshake.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [4:0]  r_rd;
    logic        r_wbValid;
    logic [4:0]  r_wbRd;
    logic [31:0] r_wbData;
    logic        r_misalign;

    logic        w_accept;
    logic        w_isMem;
    logic        w_aligned;
    logic        w_startAccess;
    logic        w_misaligned;
    logic        w_loadDone;
    logic [31:0] w_storeWdata;
    logic [3:0]  w_storeWstrb;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic [31:0] w_loadData;

    assign w_accept      = in_valid && (r_state == IDLE);
    assign w_isMem       = in_is_load || in_is_store;
    assign w_startAccess = w_accept && w_isMem && w_aligned;
    assign w_misaligned  = w_accept && w_isMem && !w_aligned;
    assign w_loadDone    = (r_state == ACCESS) && mem_ready && !r_we;

    always_comb begin
        w_aligned = 1'b1;
        case (in_funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~in_result[0];
            default: w_aligned = (in_result[1:0] == 2'b00);
        endcase
    end

    // Store data is replicated into every lane so the strobes alone pick the bytes.
    always_comb begin
        w_storeWdata = 32'h0;
        w_storeWstrb = 4'b0000;
        if (in_is_store) begin
            case (in_funct3[1:0])
                2'b00: begin
                    w_storeWdata = {4{in_store_data[7:0]}};
                    w_storeWstrb = 4'b0001 << in_result[1:0];
                end
                2'b01: begin
                    w_storeWdata = {2{in_store_data[15:0]}};
                    w_storeWstrb = 4'b0011 << in_result[1:0];
                end
                default: begin
                    w_storeWdata = in_store_data;
                    w_storeWstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_loadByte = mem_rdata[7:0];
        case (r_lane)
            2'd0: w_loadByte = mem_rdata[7:0];
            2'd1: w_loadByte = mem_rdata[15:8];
            2'd2: w_loadByte = mem_rdata[23:16];
            2'd3: w_loadByte = mem_rdata[31:24];
        endcase
        w_loadHalf = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_loadData = mem_rdata;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
            3'b001:  w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
            3'b100:  w_loadData = {24'h0, w_loadByte};
            3'b101:  w_loadData = {16'h0, w_loadHalf};
            default: w_loadData = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startAccess) w_nextState = ACCESS;
            ACCESS:  if (mem_ready)     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE);
        mem_req  = (r_state == ACCESS);
    end

    // Reset drops any outstanding access; the RAM side tolerates the abandoned request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'b0000;
            r_funct3   <= 3'b000;
            r_lane     <= 2'b00;
            r_rd       <= 5'd0;
            r_wbValid  <= 1'b0;
            r_wbRd     <= 5'd0;
            r_wbData   <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_wbValid  <= 1'b0;
            r_misalign <= w_misaligned;
            if (w_accept && !w_isMem) begin
                r_wbValid <= (in_rd != 5'd0);
                r_wbRd    <= in_rd;
                r_wbData  <= in_result;
            end
            if (w_startAccess) begin
                r_we     <= in_is_store;
                r_addr   <= {in_result[31:2], 2'b00};
                r_wdata  <= w_storeWdata;
                r_wstrb  <= w_storeWstrb;
                r_funct3 <= in_funct3;
                r_lane   <= in_result[1:0];
                r_rd     <= in_rd;
            end
            if (w_loadDone) begin
                r_wbValid <= (r_rd != 5'd0);
                r_wbRd    <= r_rd;
                r_wbData  <= w_loadData;
            end
        end
    end

    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_wstrb    = r_wstrb;
    assign wb_valid     = r_wbValid;
    assign wb_rd        = r_wbRd;
    assign wb_data      = r_wbData;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writeback and RAM
// transactions; negedge monitors pop and compare whenever the DUT presents them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_result(in_result),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wbExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chkWdata;
    } memExp_t;

    wbExp_t  wbQ[$];
    memExp_t memQ[$];
    int      misPending = 0;
    int      nCompared = 0;
    int      nMismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Writeback monitor: every wb_valid pulse must match the oldest expected entry.
    wbExp_t wbE;
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (wbQ.size() == 0) begin
                checkOutput("wbUnexpected", wb_valid, 0);
            end else begin
                wbE = wbQ.pop_front();
                checkOutput("wbRd", wb_rd, wbE.rd);
                checkOutput("wbData", wb_data, wbE.data);
            end
        end
    end

    // RAM monitor: the request fields are compared on the completing cycle.
    memExp_t memE;
    always @(negedge clk) begin
        if (!reset && mem_req && mem_ready) begin
            if (memQ.size() == 0) begin
                checkOutput("memUnexpected", mem_req, 0);
            end else begin
                memE = memQ.pop_front();
                checkOutput("memWe", mem_we, memE.we);
                checkOutput("memAddr", mem_addr, memE.addr);
                if (memE.chkWdata) checkOutput("memWdata", mem_wdata, memE.wdata);
                checkOutput("memWstrb", mem_wstrb, memE.wstrb);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && misalign_err) begin
            if (misPending > 0) misPending--;
            else checkOutput("misalignUnexpected", misalign_err, 0);
        end
    end

    task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] res, input logic [31:0] sdata, input logic [4:0] rd);
        in_valid      = 1'b1;
        in_is_load    = isLoad;
        in_is_store   = isStore;
        in_funct3     = f3;
        in_result     = res;
        in_store_data = sdata;
        in_rd         = rd;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
    endtask

    task automatic serveMem(input int k, input logic [31:0] rdata, output int lowCycles);
        lowCycles = 0;
        for (int i = 0; i <= k; i++) begin
            if (i == k) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            if (i == 0) checkOutput("memReqRise", mem_req, 1);
            if (!in_ready) lowCycles++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] expAddr,
                          input logic [31:0] rdata, input int k, input logic [4:0] rd,
                          input logic [31:0] expData, input bit chkTiming);
        int low;
        memQ.push_back('{1'b0, expAddr, 32'h0, 4'b0000, 1'b0});
        if (rd != 5'd0) wbQ.push_back('{rd, expData});
        applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, rd);
        serveMem(k, rdata, low);
        checkOutput("loadInReadyLow", low, k + 1);
        if (chkTiming) begin
            @(negedge clk);
            checkOutput("loadWbTiming", wb_valid, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] expAddr, input logic [31:0] expWdata,
                           input logic [3:0] expWstrb, input int k);
        int low;
        memQ.push_back('{1'b1, expAddr, expWdata, expWstrb, 1'b1});
        applyStimulus(1'b0, 1'b1, f3, addr, sdata, 5'd11);
        serveMem(k, 32'h0, low);
        checkOutput("storeInReadyLow", low, k + 1);
        @(negedge clk);
        checkOutput("storeNoWb", wb_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_is_load    = 1'b0;
        in_is_store   = 1'b0;
        in_funct3     = 3'b000;
        in_result     = 32'h0;
        in_store_data = 32'h0;
        in_rd         = 5'd0;
        mem_ready     = 1'b0;
        mem_rdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstMemReq", mem_req, 0);
        checkOutput("rstMemWe", mem_we, 0);
        checkOutput("rstMemAddr", mem_addr, 0);
        checkOutput("rstMemWdata", mem_wdata, 0);
        checkOutput("rstMemWstrb", mem_wstrb, 0);
        checkOutput("rstWbValid", wb_valid, 0);
        checkOutput("rstWbRd", wb_rd, 0);
        checkOutput("rstWbData", wb_data, 0);
        checkOutput("rstMisalign", misalign_err, 0);
        @(posedge clk); #1;

        $display("[TB] ALU ops");
        wbQ.push_back('{5'd5, 32'h1234_5678});
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
        checkOutput("aluWbPulse", wb_valid, 1);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd0);
        checkOutput("aluRd0NoWb", wb_valid, 0);
        @(posedge clk); #1;

        $display("[TB] byte/half loads");
        doLoad(3'b000, 32'h0000_0103, 32'h0000_0100, 32'h80FF_0011, 3, 5'd6, 32'hFFFF_FF80, 1'b1);
        doLoad(3'b100, 32'h0000_0103, 32'h0000_0100, 32'h80FF_0011, 3, 5'd7, 32'h0000_0080, 1'b1);
        doLoad(3'b001, 32'h0000_0102, 32'h0000_0100, 32'h8001_7FFF, 0, 5'd8, 32'hFFFF_8001, 1'b1);
        doLoad(3'b010, 32'h0000_0204, 32'h0000_0204, 32'h1357_9BDF, 1, 5'd10, 32'h1357_9BDF, 1'b1);
        doLoad(3'b101, 32'h0000_0100, 32'h0000_0100, 32'h8001_7FFF, 1, 5'd9, 32'h0000_7FFF, 1'b0);

        // The load's wb_valid is high now; the stage must already accept the next op.
        checkOutput("b2bInReady", in_ready, 1);
        wbQ.push_back('{5'd12, 32'h0BAD_F00D});
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0BAD_F00D, 32'h0, 5'd12);
        checkOutput("b2bAluWb", wb_valid, 1);

        $display("[TB] stores");
        doStore(3'b000, 32'h0000_0101, 32'hAABB_CCDD, 32'h0000_0100, 32'hDDDD_DDDD, 4'b0010, 1);
        doStore(3'b001, 32'h0000_0102, 32'hAABB_CCDD, 32'h0000_0100, 32'hCCDD_CCDD, 4'b1100, 0);
        doStore(3'b010, 32'h0000_0108, 32'hAABB_CCDD, 32'h0000_0108, 32'hAABB_CCDD, 4'b1111, 2);

        $display("[TB] misaligned word load");
        misPending++;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd3);
        checkOutput("misErrPulse", misalign_err, 1);
        checkOutput("misNoReq", mem_req, 0);
        checkOutput("misInReady", in_ready, 1);
        checkOutput("misNoWb", wb_valid, 0);
        wbQ.push_back('{5'd4, 32'hCAFE_0001});
        applyStimulus(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd4);
        checkOutput("misErrOnce", misalign_err, 0);
        checkOutput("misNextAluWb", wb_valid, 1);
        @(posedge clk); #1;

        $display("[TB] reset during access");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9);
        checkOutput("rstAccessReq", mem_req, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstDropReq", mem_req, 0);
        checkOutput("rstDropInReady", in_ready, 1);
        checkOutput("rstDropWb", wb_valid, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        checkOutput("rstLateReadyNoWb", wb_valid, 0);
        checkOutput("rstLateReadyIdle", in_ready, 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("wbQueueDrained", wbQ.size(), 0);
        checkOutput("memQueueDrained", memQ.size(), 0);
        checkOutput("misalignPending", misPending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Load/store stage between the ALU stage and the writeback unit of the 32-bit RISC-V pipeline. It takes ALU results, forwards non-memory results to writeback, and runs loads and stores against a single-ported data RAM with a variable-latency request/ready handshake. While an access is outstanding it stalls the ALU stage. Loads are byte/halfword/word with sign or zero extension; stores produce byte strobes.

## Interface
- No parameters; data and address widths are fixed at 32, register address at 5.
- clk  in  1  pipeline clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU stage presents an operation this cycle.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_is_load  in  1  operation is a load.
- in_is_store  in  1  operation is a store. in_is_load and in_is_store both high is illegal.
- in_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_result  in  32  ALU result; the effective address for loads/stores.
- in_store_data  in  32  rs2 value for stores.
- in_rd  in  5  destination register.
- mem_req  out  1  RAM request, held until mem_ready.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_wdata  out  32  store data replicated into lanes.
- mem_wstrb  out  4  byte write strobes; 0000 on loads.
- mem_ready  in  1  RAM completes the request this cycle; rdata is valid with it.
- mem_rdata  in  32  load word.
- wb_valid  out  1  writeback data valid (single-cycle pulse per op).
- wb_rd  out  5  writeback register address.
- wb_data  out  32  writeback value.
- misalign_err  out  1  one-cycle pulse on a misaligned access.

## Operation
- States: IDLE and ACCESS.
- IDLE, in_valid, no memory op: on the next edge, register wb_valid = (in_rd != 0), wb_rd = in_rd, wb_data = in_result. Stay in IDLE.
- IDLE, in_valid, memory op, aligned: latch the op and go to ACCESS.
  - Alignment rule: H needs addr[0] = 0; W needs addr[1:0] = 0; B is always aligned.
- IDLE, in_valid, memory op, misaligned:
  - misalign_err = 1 for one cycle.
  - No RAM request is made; wb_valid stays 0.
  - Stay in IDLE.
- ACCESS: mem_req = 1 with stable mem_we, mem_addr, mem_wdata and mem_wstrb.
  - Stay in ACCESS while mem_ready = 0.
  - When mem_ready = 1, return to IDLE on that edge.
  - For a load, that same edge also registers wb_valid = (rd != 0), wb_rd and wb_data.
  - A store never asserts wb_valid.
- Load extraction uses lane = addr[1:0]:
  - B/BU take byte [8*lane+7 : 8*lane]; H/HU take half [16*addr[1]+15 : 16*addr[1]].
  - B and H sign-extend; BU and HU zero-extend.
- Store lanes:
  - B: wdata = {4{data[7:0]}}, wstrb = 0001 << lane.
  - H: wdata = {2{data[15:0]}}, wstrb = 0011 << lane.
  - W: wdata = data, wstrb = 1111.
- mem_ready while in IDLE is ignored.
- Reset has priority over everything, including an outstanding mem_req. It returns the stage to IDLE and abandons the access; the RAM must tolerate a dropped request.

## Timing
- Reset values: state IDLE, in_ready 1, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, wb_valid 0, wb_rd 0, wb_data 0, misalign_err 0.
- A non-memory op accepted at edge N shows wb_valid high in cycle N+1, for exactly one cycle.
- Load or store accepted at edge N:
  - mem_req rises in cycle N+1.
  - If mem_ready comes k cycles after mem_req rises (k ≥ 0, 0 meaning same cycle), mem_req falls after edge N+1+k.
  - A load shows wb_valid in cycle N+2+k. Minimum load latency is 2.
- in_ready is combinational from state: it is low for every cycle in ACCESS.
- The ALU stage must hold its inputs while in_ready = 0.
- Back-to-back operation: a new op may be accepted in the same cycle wb_valid is high, because the stage is back in IDLE.
- misalign_err is registered: an op accepted at edge N pulses it in cycle N+1.

## Test plan
- Reset with mem_req high in ACCESS -> next cycle mem_req 0, in_ready 1, wb_valid 0; mem_ready asserted later causes no wb_valid.
- ALU op, rd = 5, result 0x12345678 -> wb_valid, rd 5, data 0x12345678 one cycle after accept. Same op with rd = 0 -> wb_valid stays 0.
- LB at address 0x103, mem_rdata 0x80FF0011, mem_ready delayed 3 cycles -> mem_addr 0x100, mem_wstrb 0000, in_ready low for 4 cycles, wb_data 0xFFFFFF80. Same access as LBU -> wb_data 0x00000080.
- LH at 0x102, rdata 0x8001_7FFF -> 0xFFFF8001. LHU at 0x100, same rdata -> 0x00007FFF.
- SB at 0x101, data 0xAABBCCDD -> mem_we 1, wdata 0xDDDDDDDD, wstrb 0010. SH at 0x102 -> wdata 0xCCDDCCDD, wstrb 1100. Neither asserts wb_valid.
- LW at 0x102 -> misalign_err pulses once, no mem_req, no wb_valid. An ALU op offered in the next cycle is accepted immediately.
